sort_job_scheduler: RTL
=======================

# sort_job_scheduler

Shares one 8-element byte sort engine (start/load/done protocol, sticky `done`) between up to NREQ requesters. Each requester hands over a packed 64-bit block. The scheduler arbitrates round-robin, latches the winner's block, streams it into the engine byte by byte, waits for completion with a timeout, returns the sorted block to the winner, and then pulses the engine reset to re-arm it. It sits between the client logic and the sort engine instance.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `TIMEOUT`, default 64: maximum cycles spent in WAIT before the job is aborted.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `req`  in  NREQ: request per requester. Level; sampled only in IDLE.
- `req_data`  in  NREQ*64: block for requester i at `[64i+63:64i]`; byte k at `[64i+8k+7:64i+8k]`.
- `gnt`  out  NREQ: one-hot grant, held from grant until the CLEAR cycle.
- `resp_valid`  out  NREQ: one-cycle pulse to the granted requester.
- `resp_data`  out  64: sorted block, byte 0 = smallest. Valid while `resp_valid` is high.
- `resp_err`  out  1: timeout flag, qualified by `resp_valid`.
- `busy`  out  1: high in any state other than IDLE.
- `eng_reset`  out  1: engine synchronous reset.
- `eng_start`  out  1: engine start.
- `eng_data_in`  out  8: engine load byte.
- `eng_done`  in  1: engine done. Sticky until `eng_reset`.
- `eng_sorted`  in  64: engine result, byte k = k-th smallest element.

## Operation
- States: IDLE, START, FEED, WAIT, RESP, CLEAR. The state register and all outputs are Moore, decoded from registered state.
- **IDLE**
  - If `req` is nonzero, pick the first asserted index at or after `rr_ptr`, wrapping modulo NREQ.
  - Register `gnt` as the one-hot winner and latch that requester's slice into `job_buf`.
  - Set `rr_ptr` to winner+1 (mod NREQ), then go to START.
- **START**
  - `eng_start`=1 for exactly one cycle, then go to FEED with `idx`=0.
- **FEED**
  - `eng_data_in` = `job_buf` byte `idx`.
  - `idx` increments each cycle. After `idx`=7, go to WAIT with `timer`=0.
  - Byte k is on `eng_data_in` in the (k+1)-th cycle after the START cycle.
  - `eng_data_in` = 0 outside FEED.
- **WAIT**
  - If `eng_done` is sampled high: capture `eng_sorted` into `resp_data`, clear `resp_err`, go to RESP.
  - Otherwise, if `timer` = TIMEOUT-1: set `resp_data`=0 and `resp_err`=1, go to RESP.
  - Otherwise `timer` increments. `timer` width is clog2(TIMEOUT); it never wraps.
- **RESP**
  - `resp_valid` = `gnt` for one cycle, then go to CLEAR.
- **CLEAR**
  - `eng_reset`=1 for one cycle.
  - `gnt` clears at the end of this cycle; go to IDLE.
- `eng_reset` = `reset` OR (state == CLEAR), so a scheduler reset always resets the engine as well.
- Requester behaviour while granted:
  - `req` deasserting after grant is ignored; the job completes and the response is still delivered.
  - `req_data` may change once `gnt` is seen.
- `eng_done` sampled in any state other than WAIT is ignored.
- A requester holding `req` through RESP re-enters arbitration in IDLE. It wins again only if no other requester sits at or after `rr_ptr`.

## Timing
- Reset values:
  - state=IDLE, `rr_ptr`=0, `gnt`=0, `resp_valid`=0, `resp_data`=0, `resp_err`=0, `busy`=0.
  - `eng_start`=0, `eng_data_in`=0, `eng_reset`=1 (while `reset` is high).
- Reset mid-job:
  - The job is abandoned and no response is generated.
  - `gnt` drops on the next edge and the engine is reset in the same cycle.
- Grant timing: `req` seen in IDLE at cycle 0 → `gnt` and START in cycle 1 → FEED in cycles 2..9 → WAIT from cycle 10.
- Response timing: `eng_done` sampled at edge N in WAIT → `resp_valid` in cycle N+1 → CLEAR in N+2 → IDLE in N+3.
- Back-to-back jobs: a new grant can occur at the earliest in cycle N+4.
- Minimum job length, with done on the first WAIT cycle: 14 cycles from request to IDLE.
- Timeout job: WAIT lasts exactly TIMEOUT cycles, then RESP.
- No combinational path from `req`, `req_data` or `eng_done` to any output.

## Test plan
- **Single job.** Behavioural engine model with done 12 cycles after the last byte. Requester 2, `req_data` bytes 0..7 = 07,06,05,04,03,02,01,00:
  - `gnt`=0100 in cycle 1.
  - `eng_data_in` = 07..00 in cycles 2..9.
  - `resp_valid`=0100 with `resp_data` = 0x0706050403020100 and `resp_err`=0.
  - `eng_reset` pulses in the following cycle.
- **Fairness.** `req`=1111 held continuously → grant order 0,1,2,3,0, with exactly one `resp_valid` per job.
- **Timeout.** Model never raises `eng_done`, TIMEOUT=64:
  - `resp_valid` arrives exactly 64 cycles after entering WAIT.
  - `resp_err`=1, `resp_data`=0.
  - `eng_reset` pulses and the next request is served normally.
- **Reset mid-job.** `reset` asserted during FEED at `idx`=3:
  - Next cycle: IDLE, `gnt`=0, no `resp_valid`.
  - `eng_reset` is high during reset.
  - `rr_ptr`=0 after reset.
- **Requester drops early.** Requester 1 deasserts `req` in cycle 2 and changes `req_data` → response still goes to requester 1 with the originally latched block, sorted.
- **Stale done.** `eng_done` pulsed by the model during FEED → ignored; no early RESP.

Source files
------------

// File: rtl/sort_job_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sort_job_scheduler
// Description : Round-robin scheduler sharing one 8-byte sort engine between
//               NREQ requesters (grant, stream, wait/timeout, respond, re-arm).
// Revision    : 1.0 - initial release
// ============================================================================
module sort_job_scheduler #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*64-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      resp_valid,
    output logic [63:0]          resp_data,
    output logic                 resp_err,
    output logic                 busy,
    output logic                 eng_reset,
    output logic                 eng_start,
    output logic [7:0]           eng_data_in,
    input  logic                 eng_done,
    input  logic [63:0]          eng_sorted
);

    localparam int PW = $clog2(NREQ);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_FEED  = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4,
        S_CLEAR = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [63:0]       job_buf_q, job_buf_d;
    logic [2:0]        idx_q, idx_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [63:0]       resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;

    logic              win_found;
    logic [PW-1:0]     win_idx;
    logic [PW:0]       cand_sum;
    logic [PW-1:0]     cand_idx;

    // Scan from rr_ptr upward, wrapping, and take the first active request.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        cand_idx  = '0;
        for (int off = 0; off < NREQ; off++) begin
            cand_sum = {1'b0, rr_ptr_q} + (PW+1)'(off);
            if (cand_sum >= (PW+1)'(NREQ)) begin
                cand_sum = cand_sum - (PW+1)'(NREQ);
            end
            cand_idx = cand_sum[PW-1:0];
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        job_buf_d   = job_buf_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    job_buf_d      = req_data[int'(win_idx)*64 +: 64];
                    rr_ptr_d       = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + PW'(1);
                    state_d        = S_START;
                end
            end
            S_START: begin
                idx_d   = 3'd0;
                state_d = S_FEED;
            end
            S_FEED: begin
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (eng_done) begin
                    resp_data_d = eng_sorted;
                    resp_err_d  = 1'b0;
                    state_d     = S_RESP;
                end else if (timer_q == TW'(TIMEOUT-1)) begin
                    resp_data_d = '0;
                    resp_err_d  = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_RESP: begin
                state_d = S_CLEAR;
            end
            S_CLEAR: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            job_buf_q   <= '0;
            idx_q       <= '0;
            timer_q     <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            job_buf_q   <= job_buf_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign gnt         = gnt_q;
    assign resp_valid  = (state_q == S_RESP) ? gnt_q : '0;
    assign resp_data   = resp_data_q;
    assign resp_err    = resp_err_q;
    assign busy        = (state_q != S_IDLE);
    assign eng_start   = (state_q == S_START);
    assign eng_data_in = (state_q == S_FEED) ? job_buf_q[{idx_q, 3'b000} +: 8] : 8'h00;
    // The engine is re-armed after every job and whenever the scheduler resets.
    assign eng_reset   = reset | (state_q == S_CLEAR);

endmodule
`default_nettype wire
